// File: rtl/divider_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_pkg
// Description : Shared definitions for the sequential restoring divider:
//               FSM state encodings and the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_seq_pkg;

  // FSM state encodings (explicit 2-bit width)
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  // Width of the iteration counter; it must be able to hold WIDTH itself.
  function automatic int div_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : divider_seq_pkg
`default_nettype wire

// File: rtl/divider_step.sv
`default_nettype none
// ============================================================================
// Module      : divider_step
// Description : One combinational restoring-division step. Shifts the
//               {rem, quo} pair left by one bit, trial-subtracts the divisor
//               at WIDTH+1 bits and keeps the difference when it is
//               non-negative, recording the outcome in the quotient LSB.
// Ports       : rem      - current partial remainder (WIDTH)
//               quo      - current quotient/dividend shift register (WIDTH)
//               divisor  - divisor (WIDTH)
//               rem_next - partial remainder after this step (WIDTH)
//               quo_next - quotient register after this step (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module divider_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;
  logic           w_neg;

  // The partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor. That keeps the trial difference inside the signed
  // WIDTH+1-bit range, making its MSB a reliable sign bit.
  assign w_shifted = {rem, quo[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, divisor};
  assign w_neg     = w_trial[WIDTH];

  // On a negative trial the shifted value is below the divisor, so its
  // upper bit is zero and dropping it is lossless.
  assign rem_next = w_neg ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], ~w_neg};

endmodule : divider_step
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq
// Description : Sequential unsigned restoring divider, one quotient bit per
//               clock, with valid/ready handshakes on operands and results.
//               A zero divisor completes immediately with quotient all ones,
//               remainder equal to the dividend and div_by_zero set.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - operand handshake
//               dividend, divisor   - unsigned operands (WIDTH)
//               out_valid/out_ready - result handshake
//               quotient, remainder - unsigned results (WIDTH)
//               div_by_zero         - result came from a zero divisor
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int             CNT_W     = div_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic             dbz_q,   dbz_d;

  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic             w_accept;

  divider_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (w_rem_step),
    .quo_next (w_quo_step)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dbz_q   <= dbz_d;
    end
  end

  assign w_accept = in_valid && (state_q == DIV_IDLE);

  // --------------------------------------------------------------------------
  // Next-state and datapath update
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (w_accept) begin
          dvs_d = divisor;
          cnt_d = '0;
          if (divisor == '0) begin
            // Zero divisor bypasses the iteration entirely.
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            quo_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = w_rem_step;
        quo_d = w_quo_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        if (out_ready) begin
          state_d = DIV_IDLE;
        end
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from registered state only
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready    = (state_q == DIV_IDLE);
    out_valid   = (state_q == DIV_DONE);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule : divider_seq
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq
// Description : Self-checking bench for divider_seq (WIDTH=8). Directed table
//               vectors, backpressure, mid-operation reset, and a random
//               stream checked against a reference model and the division
//               invariant, with a result scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_seq;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  divider_seq #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dbz;
    int               lat;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Pops the oldest expected result and compares it with the DUT outputs.
  task automatic check_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check({name, "_q"},   quotient,    e.q);
      check({name, "_r"},   remainder,   e.r);
      check({name, "_dbz"}, div_by_zero, e.dbz);
    end
  endtask

  // Entry and exit point: 1 time unit after a rising edge.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input exp_t e, input int exp_lat, input string name);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_in_ready"}, in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = WIDTH'($urandom); divisor = WIDTH'($urandom);
    n = 1;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check({name, "_latency"}, n, exp_lat);
    check_result(name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_idle_ready"}, in_ready, 1);
    check({name, "_idle_valid"}, out_valid, 0);
  endtask

  vec_t vecs[5];
  logic [WIDTH-1:0] ops_a[$];
  logic [WIDTH-1:0] ops_b[$];

  initial begin
    int n;
    exp_t e;
    vecs[0] = '{a: 8'd200, b: 8'd7,  q: 8'd28,  r: 8'd4,   dbz: 1'b0, lat: 9};
    vecs[1] = '{a: 8'd255, b: 8'd1,  q: 8'd255, r: 8'd0,   dbz: 1'b0, lat: 9};
    vecs[2] = '{a: 8'd5,   b: 8'd9,  q: 8'd0,   r: 8'd5,   dbz: 1'b0, lat: 9};
    vecs[3] = '{a: 8'd100, b: 8'd0,  q: 8'd255, r: 8'd100, dbz: 1'b1, lat: 1};
    vecs[4] = '{a: 8'd100, b: 8'd10, q: 8'd10,  r: 8'd0,   dbz: 1'b0, lat: 9};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready,    1);
    check("rst_out_valid", out_valid,   0);
    check("rst_quotient",  quotient,    0);
    check("rst_remainder", remainder,   0);
    check("rst_dbz",       div_by_zero, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 5; i++) begin
      e.q = vecs[i].q; e.r = vecs[i].r; e.dbz = vecs[i].dbz;
      run_op(vecs[i].a, vecs[i].b, e, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Backpressure: 77/5 held for 6 stalled cycles, stray request ignored
    dividend = 8'd77; divisor = 8'd5; in_valid = 1'b1;
    e.q = 8'd15; e.r = 8'd2; e.dbz = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_latency", n, 9);
    for (int c = 0; c < 6; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_q_hold", quotient, 15);
      check("bp_r_hold", remainder, 2);
      if (c == 2) begin dividend = 8'd9; divisor = 8'd3; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_result("bp");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    check("bp_idle_valid", out_valid, 0);
    @(posedge clk); #1;
    check("bp_no_extra", out_valid, 0);
    check("bp_sb_empty", sb.size(), 0);

    // Reset in the middle of 180/11
    dividend = 8'd180; divisor = 8'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_in_ready",  in_ready, 1);
    check("rstmid_quotient",  quotient, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      check("rstmid_no_result", out_valid, 0);
    end
    e.q = 8'd16; e.r = 8'd4; e.dbz = 1'b0;
    run_op(8'd180, 8'd11, e, 9, "after_rst");

    // Random stream with out_ready tied high
    ops_a.push_back(8'd0);   ops_b.push_back(8'd0);
    ops_a.push_back(8'd255); ops_b.push_back(8'd255);
    ops_a.push_back(8'd0);   ops_b.push_back(8'd255);
    ops_a.push_back(8'd255); ops_b.push_back(8'd0);
    ops_a.push_back(8'd0);   ops_b.push_back(8'd1);
    ops_a.push_back(8'd255); ops_b.push_back(8'd1);
    for (int i = 0; i < 1000; i++) begin
      ops_a.push_back(WIDTH'($urandom));
      ops_b.push_back(WIDTH'($urandom));
    end
    begin
      int total, idx, got, cyc, prev_acc;
      logic [WIDTH-1:0] prev_b, cur_a, cur_b;
      logic acc;
      exp_t r;
      total = ops_a.size();
      idx = 0; got = 0; cyc = 0; prev_acc = -1; prev_b = '0;
      out_ready = 1'b1;
      dividend = ops_a[0]; divisor = ops_b[0]; in_valid = 1'b1;
      cur_a = '0; cur_b = '0;
      while (got < total && cyc < 20 * total) begin
        acc = 1'b0;
        if (out_valid) begin
          r.q = quotient; r.r = remainder;
          check_result("rnd");
          if (cur_b != '0) begin
            check("rnd_invariant", 32'(r.q) * 32'(cur_b) + 32'(r.r), 32'(cur_a));
            check("rnd_rem_lt_div", 32'(r.r < cur_b), 1);
          end
          got++;
        end
        if (in_valid && in_ready) begin
          sb.push_back(model(dividend, divisor));
          if (prev_acc >= 0)
            check("rnd_spacing", cyc - prev_acc, (prev_b == '0) ? 2 : WIDTH + 2);
          prev_acc = cyc; prev_b = divisor;
          cur_a = dividend; cur_b = divisor;
          idx++;
          acc = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          if (idx < total) begin dividend = ops_a[idx]; divisor = ops_b[idx]; end
          else in_valid = 1'b0;
        end
      end
      check("rnd_results_received", got, total);
      in_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_divider_seq
`default_nettype wire
